// File: rtl/ip_sdram_arbiter.sv
// SDRAM access arbiter: VRAM port A (priority), MSX-bus port B, auto-refresh.
// One registered command at a time, req/ack downstream, read data routed back.
module ip_sdram_arbiter #(
    parameter int REFRESH_INTERVAL = 674,
    parameter int STARVE_LIMIT     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sdram_busy,
    input  logic        a_req,
    input  logic        a_wr,
    input  logic [22:0] a_address,
    input  logic [7:0]  a_wdata,
    output logic        a_ack,
    output logic [15:0] a_rdata,
    output logic        a_rdata_en,
    input  logic        b_req,
    input  logic        b_wr,
    input  logic [22:0] b_address,
    input  logic [7:0]  b_wdata,
    output logic        b_ack,
    output logic [15:0] b_rdata,
    output logic        b_rdata_en,
    output logic        mem_req,
    output logic        mem_refresh,
    output logic        mem_wr,
    output logic [22:0] mem_address,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rdata_en
);
    localparam int            TW     = $clog2(REFRESH_INTERVAL + 1);
    localparam logic [TW-1:0] RELOAD = TW'(REFRESH_INTERVAL - 1);
    localparam logic [2:0]    SLIM   = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DATA
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_ref_cnt;
    logic [2:0]    r_starve;
    logic          r_own_b;
    logic          r_a_ack;
    logic          r_b_ack;
    logic          r_a_en;
    logic          r_b_en;
    logic [15:0]   r_a_rdata;
    logic [15:0]   r_b_rdata;
    logic          r_mem_req;
    logic          r_mem_ref;
    logic          r_mem_wr;
    logic [22:0]   r_mem_addr;
    logic [7:0]    r_mem_wdata;

    logic w_a_req;
    logic w_b_req;
    logic w_gnt_ref;
    logic w_gnt_a;
    logic w_gnt_b;
    logic w_gnt;
    logic w_tick;
    logic w_issue_ack;
    logic w_rd_done;
    logic w_ref_dec;

    // A client still releasing req in its ack cycle must not win again.
    assign w_a_req     = a_req & ~r_a_ack;
    assign w_b_req     = b_req & ~r_b_ack;
    assign w_gnt       = w_gnt_ref | w_gnt_a | w_gnt_b;
    assign w_tick      = (r_timer == '0) & ~sdram_busy;
    assign w_issue_ack = (r_state == S_ISSUE) & mem_ack;
    assign w_rd_done   = (r_state == S_WAIT_DATA) & mem_rdata_en;
    assign w_ref_dec   = w_issue_ack & r_mem_ref;

    assign a_ack       = r_a_ack;
    assign b_ack       = r_b_ack;
    assign a_rdata_en  = r_a_en;
    assign b_rdata_en  = r_b_en;
    assign a_rdata     = r_a_rdata;
    assign b_rdata     = r_b_rdata;
    assign mem_req     = r_mem_req;
    assign mem_refresh = r_mem_ref;
    assign mem_wr      = r_mem_wr;
    assign mem_address = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Arbitration and next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_ref   = 1'b0;
        w_gnt_a     = 1'b0;
        w_gnt_b     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!sdram_busy) begin
                    if (r_ref_cnt != 2'd0)
                        w_gnt_ref = 1'b1;
                    else if (w_b_req && r_starve == SLIM)
                        w_gnt_b = 1'b1;
                    else if (w_a_req)
                        w_gnt_a = 1'b1;
                    else if (w_b_req)
                        w_gnt_b = 1'b1;
                end
                if (w_gnt_ref || w_gnt_a || w_gnt_b)
                    w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (mem_ack)
                    w_state_nxt = (r_mem_ref || r_mem_wr) ? S_IDLE
                                                          : S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (mem_rdata_en)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Refresh interval timer; held at reload while the controller initialises.
    always_ff @(posedge clk) begin
        if (reset || sdram_busy || r_timer == '0) r_timer <= RELOAD;
        else                                      r_timer <= r_timer - 1'b1;
    end

    // Pending refresh count, saturating at 3.
    always_ff @(posedge clk) begin
        if (reset)
            r_ref_cnt <= 2'd0;
        else if (w_tick && !w_ref_dec && r_ref_cnt != 2'd3)
            r_ref_cnt <= r_ref_cnt + 2'd1;
        else if (!w_tick && w_ref_dec)
            r_ref_cnt <= r_ref_cnt - 2'd1;
    end

    // Consecutive A grants while B waits.
    always_ff @(posedge clk) begin
        if (reset)
            r_starve <= 3'd0;
        else if (w_gnt_b)
            r_starve <= 3'd0;
        else if (w_gnt_a && !b_req)
            r_starve <= 3'd0;
        else if (w_gnt_a && r_starve != SLIM)
            r_starve <= r_starve + 3'd1;
    end

    // Command latch, downstream request and return-path strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_own_b     <= 1'b0;
            r_a_ack     <= 1'b0;
            r_b_ack     <= 1'b0;
            r_a_en      <= 1'b0;
            r_b_en      <= 1'b0;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_ref   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            r_a_en  <= 1'b0;
            r_b_en  <= 1'b0;
            if (w_gnt) begin
                r_mem_req <= 1'b1;
                r_mem_ref <= w_gnt_ref;
                r_own_b   <= w_gnt_b;
                if (w_gnt_ref) begin
                    r_mem_wr    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                end else if (w_gnt_b) begin
                    r_mem_wr    <= b_wr;
                    r_mem_addr  <= b_address;
                    r_mem_wdata <= b_wdata;
                end else begin
                    r_mem_wr    <= a_wr;
                    r_mem_addr  <= a_address;
                    r_mem_wdata <= a_wdata;
                end
            end
            if (w_issue_ack) begin
                r_mem_req <= 1'b0;
                r_mem_ref <= 1'b0;
                if (!r_mem_ref && r_mem_wr) begin
                    r_a_ack <= ~r_own_b;
                    r_b_ack <= r_own_b;
                end
            end
            if (w_rd_done) begin
                if (r_own_b) begin
                    r_b_rdata <= mem_rdata;
                    r_b_en    <= 1'b1;
                    r_b_ack   <= 1'b1;
                end else begin
                    r_a_rdata <= mem_rdata;
                    r_a_en    <= 1'b1;
                    r_a_ack   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ip_sdram_arbiter.sv
// Directed bench for ip_sdram_arbiter: writes, reads, starvation,
// refresh (second instance at interval 16), busy hold, mid-transfer reset.
module tb_ip_sdram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        busy;
    logic        a_req, a_wr, b_req, b_wr;
    logic [22:0] a_address, b_address;
    logic [7:0]  a_wdata, b_wdata;
    logic        mem_ack, mem_rdata_en;
    logic [15:0] mem_rdata;

    logic        a_ack, b_ack, a_rdata_en, b_rdata_en;
    logic [15:0] a_rdata, b_rdata;
    logic        mem_req, mem_refresh, mem_wr;
    logic [22:0] mem_address;
    logic [7:0]  mem_wdata;

    logic        f_busy, f_a_req, f_b_req, f_mem_ack, f_mem_rdata_en;
    logic        f_a_ack, f_b_ack, f_a_rdata_en, f_b_rdata_en;
    logic [15:0] f_a_rdata, f_b_rdata;
    logic        f_mem_req, f_mem_refresh, f_mem_wr;
    logic [22:0] f_mem_address;
    logic [7:0]  f_mem_wdata;

    int n_chk = 0;
    int n_err = 0;

    ip_sdram_arbiter u_dut (
        .clk(clk), .reset(reset), .sdram_busy(busy),
        .a_req(a_req), .a_wr(a_wr), .a_address(a_address),
        .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .a_rdata_en(a_rdata_en),
        .b_req(b_req), .b_wr(b_wr), .b_address(b_address),
        .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .b_rdata_en(b_rdata_en),
        .mem_req(mem_req), .mem_refresh(mem_refresh), .mem_wr(mem_wr),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_rdata_en(mem_rdata_en)
    );

    ip_sdram_arbiter #(.REFRESH_INTERVAL(16)) u_ref (
        .clk(clk), .reset(reset), .sdram_busy(f_busy),
        .a_req(f_a_req), .a_wr(a_wr), .a_address(a_address),
        .a_wdata(a_wdata), .a_ack(f_a_ack), .a_rdata(f_a_rdata),
        .a_rdata_en(f_a_rdata_en),
        .b_req(f_b_req), .b_wr(b_wr), .b_address(b_address),
        .b_wdata(b_wdata), .b_ack(f_b_ack), .b_rdata(f_b_rdata),
        .b_rdata_en(f_b_rdata_en),
        .mem_req(f_mem_req), .mem_refresh(f_mem_refresh),
        .mem_wr(f_mem_wr), .mem_address(f_mem_address),
        .mem_wdata(f_mem_wdata), .mem_ack(f_mem_ack),
        .mem_rdata(mem_rdata), .mem_rdata_en(f_mem_rdata_en)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        busy = 1'b0; a_req = 1'b0; a_wr = 1'b0; b_req = 1'b0; b_wr = 1'b0;
        a_address = '0; b_address = '0; a_wdata = '0; b_wdata = '0;
        mem_ack = 1'b0; mem_rdata_en = 1'b0; mem_rdata = '0;
        f_busy = 1'b0; f_a_req = 1'b0; f_b_req = 1'b0;
        f_mem_ack = 1'b0; f_mem_rdata_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int bad;
        int nack;
        logic prev_ref;
        int refs[$];
        int seq[$];
        int exp_seq[10];

        // ---- busy hold, then refresh cadence on the interval-16 instance
        do_reset();
        a_wr = 1'b1; b_wr = 1'b1;
        a_address = 23'h00000A; b_address = 23'h00000B;
        f_busy = 1'b1; f_a_req = 1'b1; f_b_req = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (f_mem_req || f_mem_refresh) bad++;
        end
        chk("busy_no_req", 64'(bad), 64'd0);
        f_busy = 1'b0;
        nack = 0;
        prev_ref = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            f_mem_ack = f_mem_req;
            if (k == 1)
                chk("busy_first_A", {f_mem_req, f_mem_refresh, f_mem_address},
                    {2'b10, 23'h00000A});
            if (prev_ref && (f_a_ack || f_b_ack)) nack++;
            prev_ref = f_mem_req & f_mem_refresh;
            if (f_mem_req && f_mem_refresh) begin
                refs.push_back(k);
                chk("ref_wr0", {f_mem_wr, f_mem_address}, 64'd0);
            end
        end
        f_a_req = 1'b0; f_b_req = 1'b0; f_mem_ack = 1'b0;
        chk("ref_count", 64'(refs.size()), 64'd3);
        for (int i = 0; i < refs.size() && i < 3; i++)
            chk($sformatf("ref_at_%0d", i), 64'(refs[i]), 64'(17 + 16 * i));
        chk("ref_no_client_ack", 64'(nack), 64'd0);

        // ---- reset values
        do_reset();
        chk("rst_ctl", {a_ack, b_ack, a_rdata_en, b_rdata_en,
                        mem_req, mem_refresh, mem_wr}, 64'd0);
        chk("rst_bus", {mem_address, mem_wdata}, 64'd0);
        chk("rst_rdata", {a_rdata, b_rdata}, 64'd0);

        // ---- single A write, mem_ack three cycles into the request
        a_req = 1'b1; a_wr = 1'b1; a_address = 23'h000123; a_wdata = 8'h5A;
        @(negedge clk);
        chk("wr_cmd", {mem_req, mem_refresh, mem_wr, mem_wdata},
            {3'b101, 8'h5A});
        chk("wr_addr", mem_address, 23'h000123);
        chk("wr_no_early_ack", a_ack, 1'b0);
        repeat (2) @(negedge clk);
        chk("wr_hold", {mem_req, mem_address, mem_wdata},
            {1'b1, 23'h000123, 8'h5A});
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("wr_ack", {a_ack, b_ack, mem_req}, 3'b100);
        @(negedge clk);
        chk("wr_ack_1cyc_mask", {a_ack, mem_req}, 2'b00);
        a_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("wr_no_2nd_req", mem_req, 1'b0);

        // ---- B read at top address; early rdata_en in ISSUE is ignored
        b_req = 1'b1; b_wr = 1'b0; b_address = 23'h7FFFFF;
        @(negedge clk);
        chk("rd_cmd", {mem_req, mem_wr, mem_address},
            {2'b10, 23'h7FFFFF});
        mem_ack = 1'b1; mem_rdata = 16'hDEAD; mem_rdata_en = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata_en = 1'b0;
        chk("rd_wait", {mem_req, b_ack, b_rdata_en, b_rdata}, 64'd0);
        mem_rdata = 16'hBEEF; mem_rdata_en = 1'b1;
        @(negedge clk);
        mem_rdata_en = 1'b0;
        chk("rd_data", b_rdata, 16'hBEEF);
        chk("rd_strobe", {b_rdata_en, b_ack}, 2'b11);
        chk("rd_no_a", {a_ack, a_rdata_en, a_rdata}, 64'd0);
        b_req = 1'b0;
        @(negedge clk);
        chk("rd_1cyc_hold", {b_rdata_en, b_ack, b_rdata}, {2'b00, 16'hBEEF});

        // ---- reset while waiting for read data
        a_req = 1'b1; a_wr = 1'b0; a_address = 23'h000456;
        @(negedge clk);
        chk("rm_req", {mem_req, mem_wdata}, {1'b1, 8'h5A});
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        reset = 1'b1; a_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("rm_ctl", {a_ack, b_ack, a_rdata_en, b_rdata_en,
                       mem_req, mem_refresh, mem_wr}, 64'd0);
        chk("rm_bus", {mem_address, mem_wdata}, 64'd0);
        chk("rm_rdata", {a_rdata, b_rdata}, 64'd0);
        mem_rdata = 16'h1234; mem_rdata_en = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        mem_rdata_en = 1'b0; mem_ack = 1'b0;
        chk("rm_stray", {a_ack, a_rdata_en, a_rdata, mem_req}, 64'd0);
        a_req = 1'b1; a_wr = 1'b1; a_address = 23'h000789; a_wdata = 8'h3C;
        @(negedge clk);
        chk("rm_next_cmd", {mem_req, mem_wr, mem_address, mem_wdata},
            {2'b11, 23'h000789, 8'h3C});
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rm_next_ack", a_ack, 1'b1);
        a_req = 1'b0;
        @(negedge clk);

        // ---- starvation: A always requesting, B waiting outside A acks
        do_reset();
        a_wr = 1'b1; b_wr = 1'b1;
        a_address = 23'h00000A; b_address = 23'h00000B;
        a_req = 1'b1; b_req = 1'b1;
        exp_seq = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
        for (int c = 0; c < 120 && seq.size() < 10; c++) begin
            @(negedge clk);
            mem_ack = mem_req;
            if (mem_req)
                seq.push_back(mem_address == 23'h00000B ? 2 : 1);
            b_req = ~a_ack;
        end
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("starve_n", 64'(seq.size()), 64'd10);
        for (int i = 0; i < seq.size() && i < 10; i++)
            chk($sformatf("starve_%0d", i), 64'(seq[i]), 64'(exp_seq[i]));

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
